// File: rtl/fifo_drain_if.sv
// Upstream read port and downstream valid/ready stream of fifo_drain.
interface fifo_drain_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_not_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  fifo_data,
        input  fifo_not_empty,
        input  m_ready,
        output fifo_read,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_data,
        output fifo_not_empty,
        output m_ready,
        input  fifo_read,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_drain.sv
// Drains a fixed-latency upstream fifo into a 2-entry valid/ready buffer.
module fifo_drain #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    fifo_drain_if.master  bus,
    output logic          busy,
    output logic [15:0]   drain_count
);
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;
    logic [2:0]       load;

    assign pop  = bus.m_valid && bus.m_ready;
    assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    // A read is only issued when the buffer can absorb it next cycle.
    assign bus.fifo_read = !rst && enable && bus.fifo_not_empty &&
                           (load < 3'd2);

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = head;
    assign busy        = inflight || (occ != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ         <= 2'd0;
            inflight    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            drain_count <= 16'd0;
        end else begin
            inflight <= bus.fifo_read;
            if (pop) drain_count <= drain_count + 16'd1;
            unique case (1'b1)
                inflight && !pop: begin
                    if (occ == 2'd0) head <= bus.fifo_data;
                    else             tail <= bus.fifo_data;
                    occ <= occ + 2'd1;
                end
                !inflight && pop: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                inflight && pop: begin
                    if (occ == 2'd1) begin
                        head <= bus.fifo_data;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: upstream fifo model plus read-order reference model.
module tb_fifo_drain;
    typedef logic [15:0] wq_t[$];

    logic        clk;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] drain_count;

    fifo_drain_if #(.WIDTH(16)) bus ();

    fifo_drain #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .busy        (busy),
        .drain_count (drain_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    wq_t         up_q;
    wq_t         pend;
    wq_t         got;
    int          m_if;
    int          n_reads;
    logic [15:0] dcount;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_list(input string tag, input wq_t e);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk(tag, got[i], e[i]);
    endtask

    // One clock cycle: entered at posedge+1, leaves at next posedge+1.
    task automatic tick();
        logic        v_e, pop_e, rd_e, rd, pop;
        logic [15:0] w;
        w = 16'h0;
        bus.fifo_not_empty = (up_q.size() != 0);
        #3;
        v_e   = (pend.size() - m_if) > 0;
        pop_e = v_e && bus.m_ready;
        rd_e  = enable && bus.fifo_not_empty &&
                ((pend.size() - int'(pop_e)) < 2);
        chk("m_valid", bus.m_valid, v_e);
        if (v_e) chk("m_data", bus.m_data, pend[0]);
        chk("fifo_read", bus.fifo_read, rd_e);
        chk("busy", busy, pend.size() != 0);
        chk("drain_count", drain_count, dcount);
        rd  = bus.fifo_read;
        pop = bus.m_valid && bus.m_ready;
        if (pop) begin
            got.push_back(bus.m_data);
            if (pend.size() != 0) void'(pend.pop_front());
            dcount++;
        end
        if (rd && up_q.size() != 0) begin
            w = up_q.pop_front();
            pend.push_back(w);
            n_reads++;
        end
        m_if = rd;
        @(posedge clk);
        #1;
        bus.fifo_data = rd ? w : 16'($urandom);
    endtask

    task automatic do_reset(input bit clear_up, input logic [15:0] stale);
        rst = 1'b1;
        enable = 1'b1;
        bus.fifo_not_empty = 1'b1;
        #1;
        chk("rst_fifo_read", bus.fifo_read, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_data", bus.m_data, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drain_count", drain_count, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.fifo_data = stale;
        if (clear_up) up_q.delete();
        pend.delete();
        got.delete();
        m_if = 0;
        n_reads = 0;
        dcount = 16'h0;
    endtask

    task automatic load4();
        up_q = '{16'd3, 16'd10, 16'd15, 16'd18};
    endtask

    initial begin
        wq_t exp_l;
        int  n;
        rst = 1'b1;
        enable = 1'b0;
        bus.fifo_data = 16'h0;
        bus.fifo_not_empty = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        @(posedge clk);
        #1;

        // basic drain
        do_reset(1'b1, 16'hdead);
        load4();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_list("order_basic", '{16'd3, 16'd10, 16'd15, 16'd18});
        chk("dc_basic", drain_count, 16'd4);
        chk("busy_basic", busy, 1'b0);

        // backpressure
        do_reset(1'b1, 16'hdead);
        load4();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_reads", n_reads, 2);
        chk("stall_head", bus.m_data, 16'd3);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_list("order_stall", '{16'd3, 16'd10, 16'd15, 16'd18});

        // empty upstream
        do_reset(1'b1, 16'hdead);
        for (int i = 0; i < 20; i++) tick();
        chk("empty_reads", n_reads, 0);
        chk("empty_busy", busy, 1'b0);

        // enable dropped after first read
        do_reset(1'b1, 16'hdead);
        load4();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("en_reads", n_reads, 1);
        chk_list("en_order", '{16'd3});
        chk("en_busy", busy, 1'b0);

        // reset with a buffered and an in-flight word
        do_reset(1'b1, 16'hdead);
        load4();
        bus.m_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        do_reset(1'b0, 16'd10);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_list("rst_order", '{16'd15, 16'd18});

        // randomized enable / m_ready / data
        do_reset(1'b1, 16'hdead);
        exp_l.delete();
        for (int i = 0; i < 200; i++) begin
            exp_l.push_back(16'($urandom));
            up_q.push_back(exp_l[i]);
        end
        n = 0;
        while (got.size() < 200 && n < 3000) begin
            enable = ($urandom_range(0, 3) != 0);
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("rand_timeout", n < 3000, 1'b1);
        chk_list("rand_order", exp_l);

        // drain_count wrap
        do_reset(1'b1, 16'hdead);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 65537; i++) up_q.push_back(16'(i));
        n = 0;
        while (dcount != 16'd1 || up_q.size() != 0 || pend.size() != 0) begin
            if (n >= 66000) break;
            tick();
            n++;
        end
        chk("wrap_timeout", n < 66000, 1'b1);
        chk("wrap_count", drain_count, 16'd1);
        chk("wrap_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
